noc_demux_1x4: RTL and testbench

- Output-side counterpart of the 4:1 input-select path in the hierarchical mesh NoC router.
- Takes one valid/ready input stream and delivers each flit to any subset of four output ports (unicast, multicast or broadcast), selected by a per-flit destination mask.
- Each output port has a small FIFO, so a stalled port does not corrupt in-flight data.
- There is no combinational path from any out_ready to in_ready.

---
 rtl/noc_pkg.sv | 8 +
 rtl/noc_port_fifo.sv | 35 +++
 rtl/noc_demux_1x4.sv | 55 +++++
 tb/tb_noc_demux_1x4.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared port count, mask/bus types and counter widths for the NoC demux.
package noc_pkg;
    localparam int NUM_PORTS      = 4;
    localparam int DROP_CNT_W     = 8;
    localparam int DEF_DATA_WIDTH = 16;
    typedef logic [NUM_PORTS-1:0] dest_mask_t;
    typedef logic [NUM_PORTS*DEF_DATA_WIDTH-1:0] out_bus_t;
endpackage

// File: rtl/noc_port_fifo.sv
// noc_port_fifo: per-port FIFO with wrap-bit pointers; storage clears on reset.
module noc_port_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
    assign empty     = r_wr_ptr == r_rd_ptr;
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head_data = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/noc_demux_1x4.sv
// noc_demux_1x4: atomic unicast/multicast demux of one stream into four buffered output ports.
module noc_demux_1x4
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic [NUM_PORTS-1:0]            in_dest,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_PORTS-1:0]            out_valid,
    input  logic [NUM_PORTS-1:0]            out_ready,
    output logic                            err_zero_dest,
    output logic [DROP_CNT_W-1:0]           drop_count
);
    dest_mask_t w_full;
    dest_mask_t w_empty;
    dest_mask_t w_push;
    dest_mask_t w_pop;
    logic       w_fire;
    // Ready uses only registered full flags, so out_ready never reaches in_ready.
    assign in_ready  = rst_n & (&(~in_dest | ~w_full));
    assign w_fire    = in_valid & in_ready;
    assign w_push    = {NUM_PORTS{w_fire}} & in_dest;
    assign w_pop     = ~w_empty & out_ready;
    assign out_valid = ~w_empty;
    for (genvar g = 0; g < NUM_PORTS; g++) begin : gen_port
        noc_port_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (w_push[g]),
            .push_data(in_data),
            .pop      (w_pop[g]),
            .head_data(out_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .full     (w_full[g]),
            .empty    (w_empty[g])
        );
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_zero_dest <= 1'b0;
            drop_count    <= '0;
        end else if (w_fire && in_dest == '0) begin
            err_zero_dest <= 1'b1;
            drop_count    <= (drop_count == '1) ? drop_count : drop_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_noc_demux_1x4.sv
// tb_noc_demux_1x4: vector table plus per-port scoreboard queues for the 1x4 NoC demux.
module tb_noc_demux_1x4;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int DEPTH = 2;

    logic            clk = 0;
    logic            rst_n = 0;
    logic [DW-1:0]   in_data = '0;
    logic [NP-1:0]   in_dest = '0;
    logic            in_valid = 0;
    logic            in_ready;
    logic [NP*DW-1:0] out_data;
    logic [NP-1:0]   out_valid;
    logic [NP-1:0]   out_ready = '0;
    logic            err_zero_dest;
    logic [7:0]      drop_count;

    noc_demux_1x4 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .err_zero_dest(err_zero_dest), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int n_test = 0;
    int n_fail = 0;
    logic [DW-1:0] sb [NP][$];
    logic          m_err = 0;
    logic [7:0]    m_drop = 0;

    typedef struct {
        logic          v;
        logic [NP-1:0] dest;
        logic [DW-1:0] data;
        logic [NP-1:0] ordy;
        logic          exp_rdy;
        logic [NP-1:0] exp_ov;
    } vec_t;
    vec_t tbl [21];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_test++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, compare against the scoreboard at the falling edge, then advance the model.
    task automatic step(input logic v, input logic [NP-1:0] dest, input logic [DW-1:0] data,
                        input logic [NP-1:0] ordy);
        logic m_ready;
        @(posedge clk);
        #1;
        in_valid = v; in_dest = dest; in_data = data; out_ready = ordy;
        @(negedge clk);
        m_ready = 1;
        for (int i = 0; i < NP; i++) if (dest[i] && sb[i].size() >= DEPTH) m_ready = 0;
        chk("in_ready", 64'(in_ready), 64'(m_ready));
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(sb[i].size() != 0));
            if (sb[i].size() != 0)
                chk($sformatf("out_data[%0d]", i), 64'(out_data[i*DW +: DW]), 64'(sb[i][0]));
        end
        chk("err_zero_dest", 64'(err_zero_dest), 64'(m_err));
        chk("drop_count", 64'(drop_count), 64'(m_drop));
        for (int i = 0; i < NP; i++) if (sb[i].size() != 0 && ordy[i]) void'(sb[i].pop_front());
        if (v && m_ready) begin
            if (dest == '0) begin
                m_err = 1;
                if (m_drop != 8'hFF) m_drop++;
            end else
                for (int i = 0; i < NP; i++) if (dest[i]) sb[i].push_back(data);
        end
    endtask

    initial begin
        tbl[0]  = '{1, 4'b0100, 16'hA5A5, 4'hF, 1, 4'b0000};
        tbl[1]  = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b0100};
        tbl[2]  = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b0000};
        tbl[3]  = '{1, 4'b1111, 16'h0001, 4'hD, 1, 4'b0000};
        tbl[4]  = '{1, 4'b1111, 16'h0002, 4'hD, 1, 4'b1111};
        tbl[5]  = '{1, 4'b1111, 16'h0003, 4'hD, 0, 4'b1111};
        tbl[6]  = '{1, 4'b1111, 16'h0003, 4'hF, 0, 4'b0010};
        tbl[7]  = '{1, 4'b1111, 16'h0003, 4'hF, 1, 4'b0010};
        tbl[8]  = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b1111};
        tbl[9]  = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b0000};
        tbl[10] = '{1, 4'b0001, 16'h0010, 4'h0, 1, 4'b0000};
        tbl[11] = '{1, 4'b0001, 16'h0011, 4'h0, 1, 4'b0001};
        tbl[12] = '{1, 4'b0001, 16'h0012, 4'h1, 0, 4'b0001};
        tbl[13] = '{1, 4'b0001, 16'h0012, 4'h1, 1, 4'b0001};
        tbl[14] = '{0, 4'b0000, 16'h0000, 4'h1, 1, 4'b0001};
        tbl[15] = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b0000};
        tbl[16] = '{1, 4'b0011, 16'h0020, 4'hF, 1, 4'b0000};
        tbl[17] = '{1, 4'b1100, 16'h0021, 4'hF, 1, 4'b0011};
        tbl[18] = '{1, 4'b1111, 16'h0022, 4'hF, 1, 4'b1100};
        tbl[19] = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b1111};
        tbl[20] = '{0, 4'b0000, 16'h0000, 4'hF, 1, 4'b0000};

        #1;
        chk("reset in_ready", 64'(in_ready), 64'(0));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset out_data", 64'(out_data), 64'(0));
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
        step(0, 4'b0000, 16'h0, 4'hF);

        for (int r = 0; r < 21; r++) begin
            step(tbl[r].v, tbl[r].dest, tbl[r].data, tbl[r].ordy);
            chk($sformatf("vec%0d in_ready", r), 64'(in_ready), 64'(tbl[r].exp_rdy));
            chk($sformatf("vec%0d out_valid", r), 64'(out_valid), 64'(tbl[r].exp_ov));
        end

        for (int k = 0; k < 300; k++) begin
            step(1, 4'b0000, 16'(k), 4'hF);
            if (k == 1) chk("zero err after first", 64'(err_zero_dest), 64'(1));
            if (k == 1) chk("zero drop after first", 64'(drop_count), 64'(1));
        end
        step(0, 4'b0000, 16'h0, 4'hF);
        chk("zero drop saturated", 64'(drop_count), 64'(255));
        chk("zero out_valid", 64'(out_valid), 64'(0));

        step(1, 4'b1000, 16'h0033, 4'h0);
        step(1, 4'b1000, 16'h0034, 4'h0);
        @(posedge clk); #2;
        rst_n = 0;
        #1;
        chk("async out_valid", 64'(out_valid), 64'(0));
        chk("async in_ready", 64'(in_ready), 64'(0));
        chk("async out_data", 64'(out_data), 64'(0));
        chk("async err", 64'(err_zero_dest), 64'(0));
        chk("async drop", 64'(drop_count), 64'(0));
        for (int i = 0; i < NP; i++) sb[i].delete();
        m_err = 0; m_drop = 0;
        in_valid = 0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1;
        step(1, 4'b1000, 16'h0077, 4'hF);
        step(0, 4'b0000, 16'h0, 4'hF);
        chk("post-reset out_valid", 64'(out_valid), 64'(4'b1000));
        chk("post-reset out_data", 64'(out_data[3*DW +: DW]), 64'(16'h0077));
        step(0, 4'b0000, 16'h0, 4'hF);
        chk("post-reset drained", 64'(out_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end
endmodule
